// File: rtl/tensor_core_sequencer_if.sv
// Byte-stream link between a host and the tensor core sequencer:
// command, operand input and result output channels, each valid/ready.
interface tensor_core_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic [2:0]            cmd_op;
  logic                  cmd_ready;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tensor_core_sequencer.sv
// Host-side sequencer for the 3x3 tensor core: load A/B, start, wait, drain results.
// Optional opcode checking with op_error port: define TENSOR_CORE_SEQ_OP_CHECK_EN.
module tensor_core_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic                                 tensor_core_clock,
  input  logic                                 reset_n_in,
  tensor_core_sequencer_if.slave               bus,
  input  logic                                 abort_in,
  output logic                                 busy,
  output logic [2:0][2:0][DATA_WIDTH-1:0]      core_input1,
  output logic [2:0][2:0][DATA_WIDTH-1:0]      core_input2,
  output logic                                 core_write_enable,
  output logic                                 core_start,
  output logic [2:0]                           core_operation_select,
  output logic                                 core_reset,
  input  logic [2:0][2:0][DATA_WIDTH-1:0]      core_output
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
  ,
  output logic                                 op_error
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;
  typedef logic [2:0][2:0][DATA_WIDTH-1:0] mat_t;

  localparam logic [7:0] WAIT_LOAD = 8'(COMPUTE_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] row, row_n, col, col_n;
  logic       sel_b, sel_b_n;
  logic [7:0] wait_cnt, wait_n;
  logic [2:0] op_q, op_n;
  mat_t       a_q, a_n, b_q, b_n, res_q, res_n;
  logic       idle_q, in_ready_q, out_valid_q, out_last_q;
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
  logic       op_err_n;
`endif

  // Row-major walk over a 3x3 matrix, shared by LOAD and DRAIN.
  logic       col_wrap, mat_wrap;
  logic [1:0] col_inc, row_inc;
  assign col_wrap = (col == 2'd2);
  assign mat_wrap = col_wrap && (row == 2'd2);
  assign col_inc  = col_wrap ? 2'd0 : col + 2'd1;
  assign row_inc  = col_wrap ? ((row == 2'd2) ? 2'd0 : row + 2'd1) : row;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_n  = state;
    row_n    = row;
    col_n    = col;
    sel_b_n  = sel_b;
    wait_n   = wait_cnt;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    res_n    = res_q;
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
    op_err_n = 1'b0;
`endif
    if (abort_in) begin
      state_n = S_IDLE;
      row_n   = 2'd0;
      col_n   = 2'd0;
      sel_b_n = 1'b0;
      wait_n  = 8'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
            if (bus.cmd_op > 3'd2) begin
              op_err_n = 1'b1;
            end else begin
              op_n    = bus.cmd_op;
              state_n = S_LOAD;
              row_n   = 2'd0;
              col_n   = 2'd0;
              sel_b_n = 1'b0;
            end
`else
            op_n    = bus.cmd_op;
            state_n = S_LOAD;
            row_n   = 2'd0;
            col_n   = 2'd0;
            sel_b_n = 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if (sel_b) b_n[row][col] = bus.in_data;
            else       a_n[row][col] = bus.in_data;
            col_n = col_inc;
            row_n = row_inc;
            if (mat_wrap) begin
              if (sel_b) state_n = S_START;
              sel_b_n = 1'b1;
            end
          end
        end
        S_START: begin
          state_n = S_WAIT;
          wait_n  = WAIT_LOAD;
        end
        S_WAIT: begin
          if (wait_cnt == 8'd0) begin
            res_n   = core_output;
            state_n = S_DRAIN;
            row_n   = 2'd0;
            col_n   = 2'd0;
          end else begin
            wait_n = wait_cnt - 8'd1;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            col_n = col_inc;
            row_n = row_inc;
            if (mat_wrap) state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next-state values so they are registered yet aligned with state.
  always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      // NOTE: operand/result buffers are small flop arrays and must read 0 after reset, so they are reset here.
      state             <= S_IDLE;
      row               <= 2'd0;
      col               <= 2'd0;
      sel_b             <= 1'b0;
      wait_cnt          <= 8'd0;
      op_q              <= 3'd0;
      a_q               <= '0;
      b_q               <= '0;
      res_q             <= '0;
      idle_q            <= 1'b1;
      in_ready_q        <= 1'b0;
      out_valid_q       <= 1'b0;
      out_last_q        <= 1'b0;
      busy              <= 1'b0;
      core_write_enable <= 1'b0;
      core_start        <= 1'b0;
      core_reset        <= 1'b0;
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
      op_error          <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments only; blocking ones belong in always_comb.
      state             <= state_n;
      row               <= row_n;
      col               <= col_n;
      sel_b             <= sel_b_n;
      wait_cnt          <= wait_n;
      op_q              <= op_n;
      a_q               <= a_n;
      b_q               <= b_n;
      res_q             <= res_n;
      idle_q            <= (state_n == S_IDLE);
      in_ready_q        <= (state_n == S_LOAD);
      out_valid_q       <= (state_n == S_DRAIN);
      out_last_q        <= (state_n == S_DRAIN) && (row_n == 2'd2) && (col_n == 2'd2);
      busy              <= (state_n != S_IDLE);
      core_write_enable <= (state_n == S_LOAD);
      core_start        <= (state_n == S_START);
      core_reset        <= abort_in;
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
      op_error          <= op_err_n;
`endif
    end
  end

  // A command arriving together with an abort is refused in the same cycle.
  assign bus.cmd_ready         = idle_q && !(abort_in && bus.cmd_valid);
  assign bus.in_ready          = in_ready_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_last          = out_last_q;
  assign bus.out_data          = out_valid_q ? res_q[row][col] : '0;
  assign core_input1           = a_q;
  assign core_input2           = b_q;
  assign core_operation_select = op_q;

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Directed self-checking bench for tensor_core_sequencer with a behavioural 3x3 core model.
module tb_tensor_core_sequencer;

  localparam int DW = 8;
  localparam int CC = 10;

  typedef logic [2:0][2:0][DW-1:0] mat_t;

  logic tensor_core_clock = 1'b0;
  logic reset_n_in        = 1'b0;
  logic abort_in          = 1'b0;
  logic busy, core_write_enable, core_start, core_reset;
  logic [2:0] core_operation_select;
  mat_t core_input1, core_input2, core_output;
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
  logic op_error;
`endif

  int checks   = 0;
  int failures = 0;

  tensor_core_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  tensor_core_sequencer #(.DATA_WIDTH(DW), .COMPUTE_CYCLES(CC)) dut (
    .tensor_core_clock     (tensor_core_clock),
    .reset_n_in            (reset_n_in),
    .bus                   (bus),
    .abort_in              (abort_in),
    .busy                  (busy),
    .core_input1           (core_input1),
    .core_input2           (core_input2),
    .core_write_enable     (core_write_enable),
    .core_start            (core_start),
    .core_operation_select (core_operation_select),
    .core_reset            (core_reset),
    .core_output           (core_output)
`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
    ,
    .op_error              (op_error)
`endif
  );

  always #5 tensor_core_clock = ~tensor_core_clock;

  // Reference core: matmul, elementwise add, relu(A); results truncated to DW bits.
  function automatic mat_t core_model(input logic [2:0] sel, input mat_t a, input mat_t b);
    mat_t r;
    int   acc;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = 0;
        case (sel)
          3'd0: for (int k = 0; k < 3; k++) acc += int'($signed(a[i][k])) * int'($signed(b[k][j]));
          3'd1: acc = int'($signed(a[i][j])) + int'($signed(b[i][j]));
          3'd2: acc = ($signed(a[i][j]) < 0) ? 0 : int'($signed(a[i][j]));
          default: acc = 0;
        endcase
        r[i][j] = DW'(acc);
      end
    end
    return r;
  endfunction

  always_comb core_output = core_model(core_operation_select, core_input1, core_input2);

  function automatic mat_t mk9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    mat_t m;
    int   e[9];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    e[5] = e5; e[6] = e6; e[7] = e7; e[8] = e8;
    for (int i = 0; i < 9; i++) m[i/3][i%3] = DW'(e[i]);
    return m;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tensor_core_clock);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load_bytes(input mat_t a, input mat_t b, input bit gaps, input int n);
    for (int idx = 0; idx < n; idx++) begin
      if (gaps && (idx % 2 == 1)) begin
        bus.in_valid = 1'b0;
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (idx < 9) ? a[idx/3][idx%3] : b[(idx-9)/3][(idx-9)%3];
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input mat_t exp, input int stall);
    for (int k = 0; k < 9; k++) begin
      for (int s = 0; s < stall; s++) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_data", bus.out_data, exp[k/3][k%3]);
        check("stall_busy", busy, 1'b1);
        step();
      end
      check("out_data", bus.out_data, exp[k/3][k%3]);
      check("out_last", bus.out_last, (k == 8));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    check("drain_end_valid", bus.out_valid, 1'b0);
    check("drain_end_busy", busy, 1'b0);
    check("drain_end_cmd_ready", bus.cmd_ready, 1'b1);
  endtask

  task automatic run_job(input logic [2:0] op, input mat_t a, input mat_t b,
                         input mat_t exp, input bit gaps, input int stall);
    int lat;
    send_cmd(op);
    check("load_in_ready", bus.in_ready, 1'b1);
    check("load_we", core_write_enable, 1'b1);
    check("load_busy", busy, 1'b1);
    check("load_cmd_ready", bus.cmd_ready, 1'b0);
    load_bytes(a, b, gaps, 18);
    check("start_pulse", core_start, 1'b1);
    check("start_we", core_write_enable, 1'b0);
    check("start_op", core_operation_select, op);
    check("operands_a", core_input1, a);
    check("operands_b", core_input2, b);
    step();
    check("start_once", core_start, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("latency", lat, CC + 1);
    drain(exp, stall);
  endtask

  initial begin
    automatic mat_t ident = mk9(1, 0, 0, 0, 1, 0, 0, 0, 1);
    automatic mat_t seq   = mk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    automatic mat_t fives = mk9(5, 5, 5, 5, 5, 5, 5, 5, 5);
    automatic mat_t m3    = mk9(-3, -3, -3, -3, -3, -3, -3, -3, -3);
    automatic mat_t twos  = mk9(2, 2, 2, 2, 2, 2, 2, 2, 2);
    automatic mat_t ra    = mk9(-1, 2, -3, 4, -5, 6, -7, 8, -9);
    automatic mat_t rexp  = mk9(0, 2, 0, 4, 0, 6, 0, 8, 0);
    automatic mat_t ab    = mk9(11, 12, 13, 14, 15, 16, 17, 18, 19);
    automatic mat_t da    = mk9(2, 0, 0, 0, 1, 0, 0, 0, -1);
    automatic mat_t dexp  = mk9(2, 4, 6, 4, 5, 6, -7, -8, -9);
    int vcount;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_reset", core_reset, 1'b0);
    check("rst_op", core_operation_select, 3'd0);
    check("rst_in1", core_input1, '0);
    step();
    reset_n_in = 1'b1;
    step();

    // Matmul identity x 1..9, with gaps in in_valid
    run_job(3'd0, ident, seq, seq, 1'b1, 0);
    // Add with 1-on/3-off backpressure, then relu
    run_job(3'd1, fives, m3, twos, 1'b0, 3);
    run_job(3'd2, ra, seq, rexp, 1'b0, 0);

    // Command together with abort in IDLE is refused
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd1;
    abort_in      = 1'b1;
    #1;
    check("abort_cmd_ready", bus.cmd_ready, 1'b0);
    step();
    bus.cmd_valid = 1'b0;
    abort_in      = 1'b0;
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_reset", core_reset, 1'b1);
    check("idle_abort_op", core_operation_select, 3'd2);
    step();
    check("idle_abort_reset_off", core_reset, 1'b0);

`ifdef TENSOR_CORE_SEQ_OP_CHECK_EN
    send_cmd(3'b101);
    check("operr_pulse", op_error, 1'b1);
    check("operr_busy", busy, 1'b0);
    check("operr_no_start", core_start, 1'b0);
    check("operr_op_kept", core_operation_select, 3'd2);
    check("operr_cmd_ready", bus.cmd_ready, 1'b1);
    step();
    check("operr_once", op_error, 1'b0);
    check("operr_still_idle", busy, 1'b0);
`endif

    // Abort after 7 LOAD bytes
    send_cmd(3'd0);
    load_bytes(ab, seq, 1'b0, 7);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    check("abort_core_reset", core_reset, 1'b1);
    check("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b0);
    check("abort_keeps_a20", core_input1[2][0], 8'd17);
    step();
    check("abort_reset_once", core_reset, 1'b0);
    run_job(3'd0, da, seq, dexp, 1'b0, 0);

    // Async reset mid-WAIT
    send_cmd(3'd0);
    load_bytes(ident, seq, 1'b0, 18);
    step();
    step();
    step();
    #2;
    reset_n_in = 1'b0;
    #1;
    check("areset_cmd_ready", bus.cmd_ready, 1'b1);
    check("areset_busy", busy, 1'b0);
    check("areset_out_valid", bus.out_valid, 1'b0);
    check("areset_in1", core_input1, '0);
    check("areset_op", core_operation_select, 3'd0);
    step();
    reset_n_in = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid) vcount++;
    end
    check("areset_no_out_valid", vcount, 0);
    check("areset_idle", bus.cmd_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tensor_core_sequencer.md
Name: tensor_core_sequencer

Overview:
- Initiator/host side of the small 3x3 tensor core: a byte-stream front end that loads the core's operand matrices, starts it, waits out the compute window, then streams the result matrix back out.
- Sits between a byte-wide command/data link (valid/ready) and the core's parallel matrix ports; it owns all core control (write enable, start, operation select, core reset).

Parameters:
- DATA_WIDTH, 8, element width in bits; signed two's complement; matches core bus width.
- COMPUTE_CYCLES, 10, clock cycles spent in WAIT after the start pulse before results are sampled; legal range 1..255.

Ports:
- tensor_core_clock  in  1  single clock; all logic on posedge.
- reset_n_in  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offer.
- cmd_op  in  3  operation: 000 matmul, 001 add, 010 relu.
- cmd_ready  out  1  high only in IDLE.
- abort_in  in  1  synchronous abort, any state.
- in_valid  in  1  operand byte valid.
- in_data  in  DATA_WIDTH  operand byte.
- in_ready  out  1  high only in LOAD.
- out_valid  out  1  result byte valid.
- out_data  out  DATA_WIDTH  result byte.
- out_last  out  1  high with the 9th result byte.
- out_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- core_input1  out  DATA_WIDTH x [3][3]  matrix A to core.
- core_input2  out  DATA_WIDTH x [3][3]  matrix B to core.
- core_write_enable  out  1  high throughout LOAD.
- core_start  out  1  one-cycle start pulse.
- core_operation_select  out  3  latched cmd_op.
- core_reset  out  1  one-cycle pulse on abort.
- core_output  in  DATA_WIDTH x [3][3]  result matrix from core.

Behaviour:
- Reset (async, reset_n_in=0): state IDLE. All 18 operand registers, the result buffer, the counters and the latched op clear to 0. All outputs 0 except cmd_ready=1.
- Handshakes: a transfer occurs on a posedge where valid&&ready. Producers hold valid and data stable until accepted.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_op, clear load index, go to LOAD.
- LOAD: in_ready=1, core_write_enable=1.
  - Accepted bytes 0..8 fill A row-major (idx/3, idx%3); bytes 9..17 fill B row-major.
  - Gaps in in_valid are legal; the index advances only on accept.
  - After byte 17 is accepted, go to START.
- START: exactly one cycle with core_start=1, core_write_enable=0, core_operation_select=latched op. Go to WAIT and load the wait counter with COMPUTE_CYCLES-1.
- WAIT: decrement each cycle. At 0, capture all 9 core_output elements into the result buffer on that edge and go to DRAIN.
  - Latency from START to first out_valid is COMPUTE_CYCLES+1 cycles.
- DRAIN: out_valid=1; out_data = result buffer[idx/3][idx%3], row-major.
  - idx advances only on out_ready. out_last=1 when idx==8.
  - On the accept of idx 8, go to IDLE.
  - out_ready stalls are unbounded; out_data is held stable while stalled.
- core_input1/2 continuously reflect the operand registers. They are never cleared between jobs, only overwritten.
- core_operation_select holds the last latched op in all states.
- abort_in (takes priority over every transition):
  - Next state IDLE; core_reset=1 for exactly that cycle; indices and wait counter clear.
  - Operand and result registers keep their values.
  - abort_in while IDLE still pulses core_reset.
- Simultaneous events:
  - cmd_valid together with abort_in in IDLE: the command is ignored and cmd_ready is forced 0 that cycle.
  - Reset asserted mid-LOAD or mid-DRAIN: all partial data is discarded; no out_valid after reset release until a new job completes.
- No arithmetic is performed in this block. Data passes through bit-exact, keeping its sign.

Optional Feature:
- Macro TENSOR_CORE_SEQ_OP_CHECK_EN.
- Defined:
  - cmd_op values 011..111 are accepted (cmd_ready handshake completes) but rejected.
  - Adds output port op_error (1 bit), which pulses for one cycle on that accept.
  - State stays IDLE; no LOAD, no core_start; the latched op is unchanged.
  - op_error resets to 0.
- Undefined:
  - No op_error port; any cmd_op is latched and forwarded unchecked.

Test Plan:
- Matmul: cmd_op=000; A=identity, B = bytes 1..9 -> core_start pulse once; 9 out bytes 1..9 in order; out_last on the 9th; first out_valid COMPUTE_CYCLES+1 cycles after core_start.
- Add/relu: cmd_op=001 with A all 5 and B all -3, then cmd_op=010 with A=[-1,2,-3,4,-5,6,-7,8,-9] -> outputs all 2, then [0,2,0,4,0,6,0,8,0]. A model core is used; core_operation_select must match each op.
- Backpressure: during DRAIN toggle out_ready 1 cycle on, 3 off -> no byte lost or duplicated; out_data stable while stalled; busy high until the last accept.
- Abort: assert abort_in after 7 LOAD bytes -> core_reset high exactly 1 cycle; cmd_ready=1 next cycle; a following full job produces correct results.
- Async reset: drop reset_n_in mid-WAIT between clock edges -> outputs 0 and cmd_ready=1 immediately, without a clock edge; no out_valid afterwards.
- Option (macro defined): cmd_op=101 -> op_error 1-cycle pulse; no core_start; busy stays 0; a next cmd_op=000 job runs normally.
